vote_tally: RTL and testbench

VOTE_TALLY -- requirements
Module: vote_tally

---
 rtl/vote_tally.sv | 147 ++++++++++++++
 tb/tb_vote_tally.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vote_tally.sv
// Voting session controller: opens a session on start, accepts one vote per
// voter, closes on close/full/timeout and publishes the tallied outcome.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no session since reset; votes are refused
// S_COLLECT | session open; votes accepted, timeout counter running
// S_DECIDE  | one cycle; result and tie latched from the final counts
// S_DONE    | outcome and counts held with result_valid high until start
module vote_tally #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT  = 64,
    localparam int IDW     = (N_VOTERS > 1) ? $clog2(N_VOTERS) : 1,
    localparam int CW      = $clog2(N_VOTERS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           vote_valid,
    input  logic [IDW-1:0] vote_id,
    input  logic           vote_val,
    input  logic           close,
    output logic           busy,
    output logic           vote_ack,
    output logic           vote_reject,
    output logic           result_valid,
    output logic           result,
    output logic           tie,
    output logic [CW-1:0]  yes_count,
    output logic [CW-1:0]  no_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Counter value seen in the last permitted COLLECT cycle.
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] bitmap_q, bitmap_d;
    logic [N_VOTERS-1:0] id_dec;
    logic [CW-1:0]       yes_q, yes_d, no_q, no_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                ack_q, ack_d, rej_q, rej_d;
    logic                rv_q, rv_d, result_q, result_d, tie_q, tie_d;
    logic                accept;
    logic                timeout_hit;

    // One-hot decode of vote_id; all-zero when the id is out of range.
    always_comb begin
        id_dec = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            if (vote_id == IDW'(i)) id_dec[i] = 1'b1;
        end
    end

    assign accept      = (state_q == S_COLLECT) && vote_valid &&
                         (id_dec != '0) && ((id_dec & bitmap_q) == '0);
    assign timeout_hit = (TIMEOUT != 0) && (tmr_q == TMR_LAST);

    // Next-state and datapath updates; a vote on the closing edge still counts.
    always_comb begin
        state_d  = state_q;
        bitmap_d = bitmap_q;
        yes_d    = yes_q;
        no_d     = no_q;
        tmr_d    = tmr_q;
        rv_d     = rv_q;
        result_d = result_q;
        tie_d    = tie_q;
        ack_d    = accept;
        rej_d    = vote_valid && !accept;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_COLLECT;
                    bitmap_d = '0;
                    yes_d    = '0;
                    no_d     = '0;
                    tmr_d    = '0;
                    rv_d     = 1'b0;
                    result_d = 1'b0;
                    tie_d    = 1'b0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    bitmap_d = bitmap_q | id_dec;
                    if (vote_val) yes_d = yes_q + CW'(1);
                    else          no_d  = no_q + CW'(1);
                end
                if (TIMEOUT != 0) tmr_d = tmr_q + TW'(1);
                if (close || (bitmap_d == '1) || timeout_hit) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                result_d = (yes_q > no_q);
                tie_d    = (yes_q == no_q);
                rv_d     = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any session in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bitmap_q <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            tmr_q    <= '0;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            rv_q     <= 1'b0;
            result_q <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            yes_q    <= yes_d;
            no_q     <= no_d;
            tmr_q    <= tmr_d;
            ack_q    <= ack_d;
            rej_q    <= rej_d;
            rv_q     <= rv_d;
            result_q <= result_d;
            tie_q    <= tie_d;
        end
    end

    assign busy         = (state_q == S_COLLECT) || (state_q == S_DECIDE);
    assign vote_ack     = ack_q;
    assign vote_reject  = rej_q;
    assign result_valid = rv_q;
    assign result       = result_q;
    assign tie          = tie_q;
    assign yes_count    = yes_q;
    assign no_count     = no_q;

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: directed sessions followed by random traffic, each
// cycle compared against a session-level reference model.
module tb_vote_tally;

    localparam int N   = 5;
    localparam int TO  = 8;
    localparam int IDW = 3;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           vote_valid = 1'b0;
    logic [IDW-1:0] vote_id = '0;
    logic           vote_val = 1'b0;
    logic           close = 1'b0;
    logic           busy, vote_ack, vote_reject, result_valid, result, tie;
    logic [CW-1:0]  yes_count, no_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: session open flag, cycles spent collecting, who voted,
    // running totals, and edges elapsed since the session closed (-1 = none).
    bit m_open;
    int m_k;
    bit m_seen [N];
    int m_yes, m_no;
    int m_since_close;
    bit m_ack, m_rej;

    vote_tally #(.N_VOTERS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
        .vote_id(vote_id), .vote_val(vote_val), .close(close), .busy(busy),
        .vote_ack(vote_ack), .vote_reject(vote_reject),
        .result_valid(result_valid), .result(result), .tie(tie),
        .yes_count(yes_count), .no_count(no_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_open = 1'b0;
        m_k = 0;
        for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
        m_yes = 0;
        m_no = 0;
        m_since_close = -1;
        m_ack = 1'b0;
        m_rej = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        bit rv_exp;
        rv_exp = (m_since_close >= 2);
        check_eq({ph, ".ack"},    vote_ack,     m_ack);
        check_eq({ph, ".rej"},    vote_reject,  m_rej);
        check_eq({ph, ".busy"},   busy,         m_open || (m_since_close == 1));
        check_eq({ph, ".rvalid"}, result_valid, rv_exp);
        check_eq({ph, ".result"}, result,       rv_exp && (m_yes > m_no));
        check_eq({ph, ".tie"},    tie,          rv_exp && (m_yes == m_no));
        check_eq({ph, ".yes"},    yes_count,    m_yes);
        check_eq({ph, ".no"},     no_count,     m_no);
    endtask

    // One clock cycle of stimulus; the model predicts the state after the edge.
    task automatic cyc(input bit s, input bit v, input logic [IDW-1:0] id,
                       input bit val, input bit c);
        bit was_open, can_start;
        start = s; vote_valid = v; vote_id = id; vote_val = val; close = c;
        was_open  = m_open;
        can_start = !(m_open || (m_since_close == 1));
        m_ack = was_open && v && (int'(id) < N) && !m_seen[id];
        m_rej = v && !m_ack;
        if (m_since_close >= 0 && m_since_close < 2) m_since_close++;
        if (was_open) begin
            if (m_ack) begin
                m_seen[id] = 1'b1;
                if (val) m_yes++; else m_no++;
            end
            m_k++;
            if (c || (m_yes + m_no == N) || (m_k == TO)) begin
                m_open = 1'b0;
                m_since_close = 1;
            end
        end
        if (can_start && s) begin
            m_open = 1'b1;
            m_k = 0;
            for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
            m_yes = 0;
            m_no = 0;
            m_since_close = -1;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
        start = 1'b0; vote_valid = 1'b0; vote_id = '0; vote_val = 1'b0; close = 1'b0;
    endtask

    task automatic pulse_reset();
        start = 1'b0; vote_valid = 1'b0; close = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs("rst");
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        #3;
        check_outputs("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full house auto-close: yes=3, no=2
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0); cyc(0, 1, 1, 1, 0); cyc(0, 1, 2, 0, 0);
        cyc(0, 1, 3, 1, 0); cyc(0, 1, 4, 0, 0);
        idle(3);
        // tie closed by force, vote on the closing edge counted
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 2, 1, 0);
        cyc(0, 1, 3, 0, 1);
        idle(3);
        // duplicate and out-of-range ids refused
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0); cyc(0, 1, 1, 0, 0); cyc(0, 1, 6, 1, 0);
        cyc(0, 0, 0, 0, 1);
        idle(3);
        // timeout after TO collect cycles, start while busy ignored
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(TO + 2);
        // empty session, then a vote in DONE
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        idle(2);
        cyc(0, 1, 0, 1, 0);
        // reset mid-collect, then a vote without start
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0); cyc(0, 1, 1, 0, 0);
        pulse_reset();
        cyc(0, 1, 2, 1, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                pulse_reset();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    IDW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 11) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
